// File: rtl/booth_seq_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// booth_seq_ctrl
//   Sequencing controller for a radix-2 Booth multiplier. A start in IDLE
//   loads the operands. The controller then performs one add/subtract plus
//   arithmetic-shift step per multiplier bit. The last step registers the
//   product and raises a one-cycle done pulse. Operands and product are
//   two's-complement signed.
//
//   Optional feature macro: BOOTH_ABORT_EN
//     When defined, the module has an abort input. Asserting abort in RUN or
//     DONE returns the controller to IDLE, suppresses done, and leaves the
//     product register unchanged.
//
// Ports
//   clk     : single clock, rising edge
//   rst     : synchronous, active-high reset
//   start   : request a multiply; accepted only in IDLE
//   mcand   : multiplicand M, sampled on the accepted start edge
//   mplier  : multiplier Q, sampled on the accepted start edge
//   abort   : (BOOTH_ABORT_EN only) cancel the operation in flight
//   product : signed 2*WIDTH result; valid with done, held until replaced
//   busy    : high in RUN and DONE
//   done    : one-cycle pulse marking product valid
// ---------------------------------------------------------------------------
module booth_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
`ifdef BOOTH_ABORT_EN
    input  logic                 abort,
`endif
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_reg, state_next;

    // A carries one guard bit, so A - M cannot overflow when M = -2^(WIDTH-1).
    logic [WIDTH:0]       a_reg;
    logic [WIDTH-1:0]     q_reg;
    logic                 q1_reg;
    logic [WIDTH-1:0]     m_reg;
    logic [CW-1:0]        cnt_reg;
    logic [2*WIDTH-1:0]   product_reg;

    logic                 abort_w;
    logic [WIDTH:0]       m_ext;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       a_shift;
    logic [WIDTH-1:0]     q_shift;
    logic                 q1_shift;
    logic                 last_step;

`ifdef BOOTH_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // ---------------------------------------------------------------
    // One Booth step: add/subtract selected by {Q[0],Q_1}, then an
    // arithmetic right shift of {A',Q,Q_1}.
    // ---------------------------------------------------------------
    assign m_ext = {m_reg[WIDTH-1], m_reg};

    always_comb begin
        sum = a_reg;
        case ({q_reg[0], q1_reg})
            2'b10:   sum = a_reg - m_ext;
            2'b01:   sum = a_reg + m_ext;
            default: sum = a_reg;
        endcase
    end

    assign a_shift          = {sum[WIDTH], sum[WIDTH:1]};
    assign q_shift[WIDTH-1] = sum[0];
    assign q1_shift         = q_reg[0];

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_q_shift
            assign q_shift[gi] = q_reg[gi+1];
        end
    endgenerate

    // The step taken while cnt==1 is the final one.
    assign last_step = (cnt_reg == CW'(1));

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic (abort outranks normal sequencing, start in
    // IDLE outranks abort because abort is ignored there)
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_RUN;
            end
            S_RUN: begin
                if (abort_w)        state_next = S_IDLE;
                else if (last_step) state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        busy = (state_reg != S_IDLE);
        done = (state_reg == S_DONE) && !abort_w;
    end

    assign product = product_reg;

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg       <= '0;
            q_reg       <= '0;
            q1_reg      <= 1'b0;
            m_reg       <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        m_reg   <= mcand;
                        q_reg   <= mplier;
                        a_reg   <= '0;
                        q1_reg  <= 1'b0;
                        cnt_reg <= CW'(WIDTH);
                    end
                end
                S_RUN: begin
                    if (!abort_w) begin
                        a_reg   <= a_shift;
                        q_reg   <= q_shift;
                        q1_reg  <= q1_shift;
                        cnt_reg <= cnt_reg - CW'(1);
                        // Product is captured on the edge that enters DONE.
                        if (last_step) begin
                            product_reg <= {a_shift[WIDTH-1:0], q_shift};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
